// File: rtl/sd_block_responder.sv
// sd_block_responder
//   Device side of the sd_rd/sd_wr/sd_ack sector interface. Moves 512-byte
//   sectors between the initiator's sector buffer and a byte-addressed image
//   store, and announces newly mounted images via img_mounted/img_size.
//
// Ports
//   clk, reset                     system clock, synchronous active-high reset
//   mount_req, mount_size          request to announce an image of mount_size bytes
//   img_mounted, img_size          one-cycle mount pulse, latched image size
//   lba, sd_rd, sd_wr              sector number and level-sensitive requests
//   sd_ack                         high while a sector transfer is in progress
//   sd_buff_addr                   byte index within the sector
//   sd_buff_wr, sd_buff_dout       read-direction byte strobe and data
//   sd_buff_din                    write-direction data, valid 1 cycle after sd_buff_addr
//   mem_addr, mem_rd, mem_wr       image-store byte address and access strobes
//   mem_wdata, mem_rdata           image-store write / read data
//   mem_ready                      completes the outstanding image-store access
//   oob_count                      saturating count of out-of-range requests
//
// state   | meaning
// IDLE    | announce a pending mount, or wait for sd_rd / sd_wr
// DELAY   | count down ACK_DELAY before raising sd_ack
// RD_MEM  | read strobe issued for byte idx, waiting for mem_ready
// RD_PUT  | byte idx presented to the initiator with sd_buff_wr
// WR_ADDR | sd_buff_addr = idx, initiator fetching the byte
// WR_MEM  | sample sd_buff_din, strobe mem_wr, wait for mem_ready
// W4REL   | sector done, wait until both requests are released
module sd_block_responder #(
    parameter int ACK_DELAY = 4,
    parameter int MEM_AW    = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mount_req,
    input  logic [63:0]       mount_size,
    output logic              img_mounted,
    output logic [63:0]       img_size,
    input  logic [31:0]       lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic              sd_buff_wr,
    output logic [7:0]        sd_buff_dout,
    input  logic [7:0]        sd_buff_din,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       oob_count
);

    typedef enum logic [2:0] {
        IDLE, DELAY, RD_MEM, RD_PUT, WR_ADDR, WR_MEM, W4REL
    } state_t;

    state_t      state;
    logic [31:0] lba_q;
    logic        is_rd;
    logic        oob;
    logic [7:0]  dly_cnt;
    logic [8:0]  idx;
    logic        wr_pend;
    logic        mount_pend;
    logic [63:0] mount_size_q;

    logic [40:0]       last_byte;
    logic              oob_now;
    logic [8:0]        idx_nxt;
    logic [MEM_AW-10:0] sec;

    // Last byte of the sector at full width so a large lba cannot wrap past img_size.
    always_comb begin
        last_byte = {lba_q, 9'h1FF};
        oob_now   = ({23'd0, last_byte} >= img_size) || ((lba_q >> (MEM_AW - 9)) != 32'd0);
    end

    assign idx_nxt = idx + 9'd1;
    assign sec     = lba_q[MEM_AW-10:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lba_q        <= '0;
            is_rd        <= 1'b0;
            oob          <= 1'b0;
            dly_cnt      <= '0;
            idx          <= '0;
            wr_pend      <= 1'b0;
            mount_pend   <= 1'b0;
            mount_size_q <= '0;
            img_mounted  <= 1'b0;
            img_size     <= '0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_wr   <= 1'b0;
            sd_buff_dout <= '0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            oob_count    <= '0;
        end else begin
            img_mounted <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;

            case (state)
                IDLE: begin
                    if (mount_pend) begin
                        img_mounted <= 1'b1;
                        img_size    <= mount_size_q;
                        mount_pend  <= 1'b0;
                    end else if (sd_rd || sd_wr) begin
                        lba_q   <= lba;
                        is_rd   <= sd_rd;
                        dly_cnt <= 8'(ACK_DELAY - 1);
                        state   <= DELAY;
                    end
                end

                DELAY: begin
                    if (dly_cnt != 8'd0) begin
                        dly_cnt <= dly_cnt - 8'd1;
                    end else begin
                        sd_ack       <= 1'b1;
                        idx          <= '0;
                        sd_buff_addr <= '0;
                        oob          <= oob_now;
                        if (oob_now && oob_count != 16'hFFFF)
                            oob_count <= oob_count + 16'd1;
                        if (is_rd) begin
                            if (oob_now) begin
                                sd_buff_wr   <= 1'b1;
                                sd_buff_dout <= 8'h00;
                                state        <= RD_PUT;
                            end else begin
                                mem_rd   <= 1'b1;
                                mem_addr <= {sec, 9'd0};
                                state    <= RD_MEM;
                            end
                        end else begin
                            state <= WR_ADDR;
                        end
                    end
                end

                RD_MEM: begin
                    // mem_ready is ignored during the strobe cycle itself
                    if (!mem_rd && mem_ready) begin
                        sd_buff_dout <= mem_rdata;
                        sd_buff_wr   <= 1'b1;
                        sd_buff_addr <= idx;
                        state        <= RD_PUT;
                    end
                end

                RD_PUT: begin
                    if (idx == 9'd511) begin
                        sd_buff_wr <= 1'b0;
                        sd_ack     <= 1'b0;
                        state      <= W4REL;
                    end else begin
                        idx <= idx_nxt;
                        if (oob) begin
                            // zero bytes streamed back to back, sd_buff_wr stays high
                            sd_buff_addr <= idx_nxt;
                        end else begin
                            sd_buff_wr <= 1'b0;
                            mem_rd     <= 1'b1;
                            mem_addr   <= {sec, idx_nxt};
                            state      <= RD_MEM;
                        end
                    end
                end

                WR_ADDR: begin
                    state <= WR_MEM;
                end

                WR_MEM: begin
                    if (oob || (wr_pend && !mem_wr && mem_ready)) begin
                        wr_pend <= 1'b0;
                        if (idx == 9'd511) begin
                            sd_ack <= 1'b0;
                            state  <= W4REL;
                        end else begin
                            idx          <= idx_nxt;
                            sd_buff_addr <= idx_nxt;
                            state        <= WR_ADDR;
                        end
                    end else if (!wr_pend) begin
                        mem_wdata <= sd_buff_din;
                        mem_wr    <= 1'b1;
                        mem_addr  <= {sec, idx};
                        wr_pend   <= 1'b1;
                    end
                end

                W4REL: begin
                    if (!sd_rd && !sd_wr) begin
                        sd_buff_addr <= '0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase

            // Placed after the case so a request in the announce cycle is kept.
            if (mount_req) begin
                mount_pend   <= 1'b1;
                mount_size_q <= mount_size;
            end
        end
    end

endmodule
